conv_acc_sink: RTL and testbench

- Receive end of the MAC array output stream: consumes per-column partial sums tagged first/last/valid.
- Tolerates the array's 16-cycle delayed ready: every beat is captured in an input FIFO; ready is throttled by free space.
- Accumulates beats from first to last per column, then applies rounding shift, optional ReLU and signed saturation.
- Emits one quantized output vector per group toward the output buffer over a valid/ready stream.

---
 rtl/conv_acc_sink.sv | 141 ++++++++++++++
 tb/tb_conv_acc_sink.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_acc_sink.sv
// conv_acc_sink: receive end of the MAC array output stream.
// Beats are always captured into an input FIFO (the array reacts to ready
// 16 cycles late), accumulated per column from first to last, then rounded,
// optionally ReLU-clamped and saturated into one output vector per group.
//
// Handshakes: the input side is valid-only; a beat is written whenever
// acc_m_valid=1 and the FIFO has room, and acc_m_ready is only a hint that
// at least SKID entries are free. The output side is strict valid/ready:
// acc_s_data is held stable while acc_s_valid=1 and is transferred on a
// cycle where acc_s_valid=1 and acc_s_ready=1.
module conv_acc_sink #(
  parameter int COLUMN = 6,
  parameter int OW     = 22,
  parameter int AW     = 32,
  parameter int QW     = 8,
  parameter int DEPTH  = 32,
  parameter int SKID   = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COLUMN*OW-1:0]  acc_m_data,
  input  logic                  acc_m_first,
  input  logic                  acc_m_last,
  input  logic                  acc_m_valid,
  output logic                  acc_m_ready,
  input  logic [4:0]            shift,
  input  logic                  relu_en,
  output logic [COLUMN*QW-1:0]  acc_s_data,
  output logic                  acc_s_valid,
  input  logic                  acc_s_ready,
  output logic                  ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = COLUMN*OW + 2;
  localparam logic signed [AW:0] QMAX = (AW+1)'((1 << (QW-1)) - 1);
  localparam logic signed [AW:0] QMIN = -QMAX - (AW+1)'(1);

  // FIFO entry layout: {data, first, last}
  logic [EW-1:0]           mem [DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PW:0]             count;
  logic                    full;
  logic                    empty;
  logic                    wr_en;
  logic                    pop;
  logic [EW-1:0]           head;
  logic                    head_first;
  logic                    head_last;
  logic signed [AW-1:0]    acc [COLUMN];
  logic signed [AW-1:0]    sum [COLUMN];
  logic [COLUMN*QW-1:0]    quant;

  // Round half up by shift, optional ReLU, then signed saturation to QW bits.
  function automatic logic [QW-1:0] quantize(input logic signed [AW-1:0] s,
                                             input logic [4:0] sh,
                                             input logic relu);
    logic signed [AW:0] ext;
    logic signed [AW:0] bias;
    logic signed [AW:0] r;
    logic [AW:0]        q;
    ext  = {s[AW-1], s};
    bias = (AW+1)'(1) << (sh - 5'd1);
    if (sh == 5'd0) r = ext;
    else            r = (ext + bias) >>> sh;
    if (relu && (r < 0)) r = '0;
    if (r > QMAX)      q = QMAX;
    else if (r < QMIN) q = QMIN;
    else               q = r;
    return q[QW-1:0];
  endfunction

  assign full       = (count == (PW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign wr_en      = acc_m_valid && !full;
  assign head       = mem[rd_ptr];
  assign head_first = head[1];
  assign head_last  = head[0];
  // A last beat may only pop when the output register can take its result.
  assign pop        = !empty && (!head_last || !acc_s_valid || acc_s_ready);

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {acc_m_data, acc_m_first, acc_m_last};
  end

  // FIFO pointers, occupancy, registered ready hint and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      acc_m_ready <= 1'b1;
      ovf         <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      acc_m_ready <= (((PW+1)'(DEPTH) - count) >= (PW+1)'(SKID));
      if (acc_m_valid && full) ovf <= 1'b1;
    end
  end

  // Per-lane running sum of the head beat and its quantized result.
  always_comb begin
    quant = '0;
    for (int k = 0; k < COLUMN; k++) begin
      sum[k] = {{(AW-OW){head[2 + k*OW + OW-1]}}, head[2 + k*OW +: OW]};
      if (!head_first) sum[k] = acc[k] + sum[k];
      quant[k*QW +: QW] = quantize(sum[k], shift, relu_en);
    end
  end

  // Accumulators: load or add on every pop, cleared when a group completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < COLUMN; k++) acc[k] <= '0;
    end else if (pop) begin
      for (int k = 0; k < COLUMN; k++) acc[k] <= head_last ? '0 : sum[k];
    end
  end

  // Output register: reload on a completing pop, otherwise drop after transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_s_data  <= '0;
      acc_s_valid <= 1'b0;
    end else if (pop && head_last) begin
      acc_s_data  <= quant;
      acc_s_valid <= 1'b1;
    end else if (acc_s_ready) begin
      acc_s_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_acc_sink.sv
// Bench for conv_acc_sink: directed scenarios plus randomized groups checked
// against an arithmetic reference model of accumulate/round/ReLU/saturate.
module tb_conv_acc_sink;

  localparam int COLUMN = 6;
  localparam int OW     = 22;
  localparam int QW     = 8;
  localparam int DW     = COLUMN*OW;
  localparam int QDW    = COLUMN*QW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DW-1:0]   acc_m_data = '0;
  logic            acc_m_first = 1'b0;
  logic            acc_m_last = 1'b0;
  logic            acc_m_valid = 1'b0;
  logic            acc_m_ready;
  logic [4:0]      shift = '0;
  logic            relu_en = 1'b0;
  logic [QDW-1:0]  acc_s_data;
  logic            acc_s_valid;
  logic            acc_s_ready = 1'b1;
  logic            ovf;

  conv_acc_sink dut (
    .clk(clk), .rst_n(rst_n),
    .acc_m_data(acc_m_data), .acc_m_first(acc_m_first), .acc_m_last(acc_m_last),
    .acc_m_valid(acc_m_valid), .acc_m_ready(acc_m_ready),
    .shift(shift), .relu_en(relu_en),
    .acc_s_data(acc_s_data), .acc_s_valid(acc_s_valid), .acc_s_ready(acc_s_ready),
    .ovf(ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [QDW-1:0] exp_q[$];
  logic [QDW-1:0] obs_q[$];
  int m_acc[COLUMN];
  int lv[COLUMN];

  // Every transfer on the output stream is recorded for the tests to inspect.
  always @(negedge clk) begin
    if (rst_n && acc_s_valid && acc_s_ready) obs_q.push_back(acc_s_data);
  end

  function automatic logic [DW-1:0] pack_lanes();
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < COLUMN; k++) d[k*OW +: OW] = OW'(lv[k]);
    return d;
  endfunction

  function automatic logic [QDW-1:0] pack_q(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5);
    int a[COLUMN];
    logic [QDW-1:0] o;
    a = '{a0, a1, a2, a3, a4, a5};
    o = '0;
    for (int k = 0; k < COLUMN; k++) o[k*QW +: QW] = QW'(a[k]);
    return o;
  endfunction

  // Reference model: integer sums, floor division for rounding, clamp to range.
  function automatic void model_beat(input bit first, input bit last);
    logic [QDW-1:0] o;
    int     s;
    int     sh;
    longint n;
    longint dv;
    longint q;
    o  = '0;
    sh = int'(shift);
    for (int k = 0; k < COLUMN; k++) begin
      s = first ? lv[k] : m_acc[k] + lv[k];
      if (last) begin
        n = longint'(s);
        if (sh > 0) begin
          dv = longint'(1) << sh;
          n  = n + dv / 2;
          q  = n / dv;
          if ((n % dv != 0) && (n < 0)) q = q - 1;
        end else begin
          q = n;
        end
        if (relu_en && q < 0) q = 0;
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        o[k*QW +: QW] = QW'(q);
        m_acc[k] = 0;
      end else begin
        m_acc[k] = s;
      end
    end
    if (last) exp_q.push_back(o);
  endfunction

  function automatic void rand_lanes();
    for (int k = 0; k < COLUMN; k++) begin
      if ($urandom_range(0, 1) == 1) lv[k] = int'($urandom_range(0, 4194303)) - 2097152;
      else                           lv[k] = int'($urandom_range(0, 1023)) - 512;
    end
  endfunction

  // driver tasks
  task automatic send_beat(input bit first, input bit last, input bit do_model);
    acc_m_data  = pack_lanes();
    acc_m_first = first;
    acc_m_last  = last;
    acc_m_valid = 1'b1;
    @(posedge clk); #1;
    acc_m_valid = 1'b0;
    if (do_model) model_beat(first, last);
  endtask

  task automatic apply_reset();
    acc_m_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < COLUMN; k++) m_acc[k] = 0;
    exp_q.delete();
    obs_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    chk_cnt++; if (acc_m_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", acc_m_ready); else pass_cnt++;
    chk_cnt++; if (acc_s_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", acc_s_valid); else pass_cnt++;
    chk_cnt++; if (acc_s_data !== '0) $display("FAIL reset_data: got %h want 0", acc_s_data); else pass_cnt++;
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else pass_cnt++;
  endtask

  task automatic test_single();
    logic [QDW-1:0] want;
    shift = 5'd0; relu_en = 1'b0; acc_s_ready = 1'b1;
    want = pack_q(5, -3, 127, -128, 0, 127);
    lv = '{5, -3, 200, -200, 0, 127};
    send_beat(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk_cnt++; if (acc_s_valid !== 1'b0) $display("FAIL single_t1_valid: got %b want 0", acc_s_valid); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (acc_s_valid !== 1'b1) $display("FAIL single_t2_valid: got %b want 1", acc_s_valid); else pass_cnt++;
    chk_cnt++; if (acc_s_data !== want) $display("FAIL single_t2_data: got %h want %h", acc_s_data, want); else pass_cnt++;
    @(posedge clk); #1;
    wait_drain();
    chk_cnt++; if (obs_q.size() != 1 || exp_q.size() != 1) $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else begin
      pass_cnt++;
      chk_cnt++; if (obs_q[0] !== exp_q[0]) $display("FAIL single_model: got %h want %h", obs_q[0], exp_q[0]); else pass_cnt++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_three_beat();
    logic [QDW-1:0] want;
    shift = 5'd2; relu_en = 1'b0; acc_s_ready = 1'b1;
    want = pack_q(15, 16, -1, 0, 0, 0);
    lv = '{10, 20, -1, 0, 0, 0}; send_beat(1'b1, 1'b0, 1'b1);
    lv = '{20, 21, -1, 0, 0, 0}; send_beat(1'b0, 1'b0, 1'b1);
    lv = '{30, 21, -1, 0, 0, 0}; send_beat(1'b0, 1'b1, 1'b1);
    wait_drain();
    chk_cnt++; if (obs_q.size() != 1) $display("FAIL three_count: got %0d want 1", obs_q.size());
    else begin
      pass_cnt++;
      chk_cnt++; if (obs_q[0] !== want) $display("FAIL three_data: got %h want %h", obs_q[0], want); else pass_cnt++;
      chk_cnt++; if (obs_q[0] !== exp_q[0]) $display("FAIL three_model: got %h want %h", obs_q[0], exp_q[0]); else pass_cnt++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_relu();
    logic [QDW-1:0] want_on;
    logic [QDW-1:0] want_off;
    shift = 5'd0; acc_s_ready = 1'b1;
    want_on  = pack_q(0, 50, 0, 0, 0, 0);
    want_off = pack_q(-50, 50, 0, 0, 0, 0);
    lv = '{-50, 50, 0, 0, 0, 0};
    relu_en = 1'b1; send_beat(1'b1, 1'b1, 1'b1); wait_drain();
    relu_en = 1'b0; send_beat(1'b1, 1'b1, 1'b1); wait_drain();
    chk_cnt++; if (obs_q.size() != 2) $display("FAIL relu_count: got %0d want 2", obs_q.size());
    else begin
      pass_cnt++;
      chk_cnt++; if (obs_q[0] !== want_on) $display("FAIL relu_on: got %h want %h", obs_q[0], want_on); else pass_cnt++;
      chk_cnt++; if (obs_q[1] !== want_off) $display("FAIL relu_off: got %h want %h", obs_q[1], want_off); else pass_cnt++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // Sender reacts to ready 15 cycles late; with ready's own register stage
  // that is the full 16-cycle loop the skid region is sized for.
  task automatic test_backpressure();
    bit rh[$];
    int sent;
    int first_low;
    bit drive;
    shift = 5'd0; relu_en = 1'b0; acc_s_ready = 1'b0;
    repeat (15) rh.push_back(1'b1);
    sent = 0; first_low = -1;
    for (int c = 0; c < 160; c++) begin
      if (c == 40) acc_s_ready = 1'b1;
      drive = rh.pop_front() && (sent < 48);
      if (drive) begin
        rand_lanes();
        acc_m_data = pack_lanes(); acc_m_first = 1'b1; acc_m_last = 1'b1;
      end
      acc_m_valid = drive;
      @(negedge clk);
      rh.push_back(acc_m_ready);
      if (!acc_m_ready && first_low < 0) first_low = sent;
      @(posedge clk); #1;
      if (drive) begin sent++; model_beat(1'b1, 1'b1); end
    end
    acc_m_valid = 1'b0;
    wait_drain();
    chk_cnt++; if (first_low != 18) $display("FAIL bp_ready_fall: got %0d beats want 18", first_low); else pass_cnt++;
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL bp_ovf: got %b want 0", ovf); else pass_cnt++;
    chk_cnt++; if (obs_q.size() != 48) $display("FAIL bp_count: got %0d want 48", obs_q.size());
    else begin
      pass_cnt++;
      for (int i = 0; i < 48; i++) begin
        chk_cnt++; if (obs_q[i] !== exp_q[i]) $display("FAIL bp_data[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); else pass_cnt++;
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // A stuck result plus a blocked last beat at the head lets the FIFO fill.
  task automatic test_overflow();
    shift = 5'd0; relu_en = 1'b0; acc_s_ready = 1'b0;
    lv = '{1, 2, 3, 4, 5, 6};
    send_beat(1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send_beat(1'b1, 1'b1, 1'b0);
    for (int i = 2; i <= 32; i++) send_beat(1'b1, 1'b0, 1'b0);
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL ovf_beat32: got %b want 0", ovf); else pass_cnt++;
    chk_cnt++; if (acc_m_ready !== 1'b0) $display("FAIL ovf_ready_full: got %b want 0", acc_m_ready); else pass_cnt++;
    send_beat(1'b1, 1'b0, 1'b0);
    chk_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_beat33: got %b want 1", ovf); else pass_cnt++;
    acc_s_ready = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf); else pass_cnt++;
    apply_reset();
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL ovf_cleared: got %b want 0", ovf); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [QDW-1:0] want;
    shift = 5'd0; relu_en = 1'b0; acc_s_ready = 1'b1;
    want = pack_q(7, 7, 7, 7, 7, 7);
    lv = '{100, 100, 100, 100, 100, 100};
    send_beat(1'b1, 1'b0, 1'b1);
    send_beat(1'b0, 1'b0, 1'b1);
    apply_reset();
    lv = '{7, 7, 7, 7, 7, 7};
    send_beat(1'b0, 1'b1, 1'b1);
    wait_drain();
    repeat (10) @(posedge clk);
    #1;
    chk_cnt++; if (obs_q.size() != 1) $display("FAIL rstmid_count: got %0d want 1", obs_q.size());
    else begin
      pass_cnt++;
      chk_cnt++; if (obs_q[0] !== want) $display("FAIL rstmid_data: got %h want %h", obs_q[0], want); else pass_cnt++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    bit done;
    int len;
    int g;
    for (int batch = 0; batch < 3; batch++) begin
      shift   = (batch == 2) ? 5'd31 : 5'($urandom_range(0, 12));
      relu_en = 1'($urandom_range(0, 1));
      done = 1'b0;
      fork
        begin
          for (int grp = 0; grp < 25; grp++) begin
            len = int'($urandom_range(1, 4));
            for (int b = 0; b < len; b++) begin
              g = 0;
              while (!acc_m_ready && g < 500) begin @(posedge clk); #1; g++; end
              rand_lanes();
              send_beat(b == 0, b == len - 1, 1'b1);
            end
          end
          done = 1'b1;
        end
        begin
          while (!done) begin
            acc_s_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
          end
        end
      join
      acc_s_ready = 1'b1;
      wait_drain();
      chk_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL rand_count[%0d]: got %0d want %0d", batch, obs_q.size(), exp_q.size());
      else begin
        pass_cnt++;
        for (int i = 0; i < exp_q.size(); i++) begin
          chk_cnt++; if (obs_q[i] !== exp_q[i]) $display("FAIL rand_data[%0d][%0d]: got %h want %h", batch, i, obs_q[i], exp_q[i]); else pass_cnt++;
        end
      end
      exp_q.delete(); obs_q.delete();
    end
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL rand_ovf: got %b want 0", ovf); else pass_cnt++;
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_single();
    test_three_beat();
    test_relu();
    test_backpressure();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
